// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart0 serial blocks (rx now, tx later).
//   uart_state_e : receiver/transmitter frame state
//   DATA_BITS    : payload bits per frame (8N1)
//   calc_div     : clock cycles per bit, integer truncated
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs.
//   clk_i  : destination clock
//   rst_ni : synchronous reset, active-low; both flops load RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output (2-cycle latency)
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, counterpart to the uart0 transmitter.
//   sys_clk     : system clock, rising edge
//   sys_rst     : synchronous reset, active-low (0 = reset)
//   uart_rx_i   : asynchronous serial line, idle high
//   rx_data     : received byte, stable while rx_valid=1
//   rx_valid    : rx_data holds an unconsumed byte
//   rx_ready    : consumer accepts; transfer when rx_valid && rx_ready
//   frame_err   : one-cycle pulse, stop bit sampled 0
//   overrun     : one-cycle pulse, byte completed while previous still unconsumed
//   dbg_state_o : current receive state, for observation only
//
// Output handshake: rx_data/rx_valid form a valid/ready source. Once rx_valid
// rises, rx_data is held until a cycle with rx_valid && rx_ready; rx_valid
// then drops on the next edge unless a new byte lands on that same edge.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 30000000,
   parameter int BAUD   = 115200
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 uart_rx_i,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output uart_state_e          dbg_state_o
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LD  = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LD  = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic rx_s;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst),
      .d_i    (uart_rx_i),
      .q_o    (rx_s)
   );

   uart_state_e          state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 tick;

   assign tick = (baud_q == '0);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = tick ? baud_q : baud_q - CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Half-bit load puts every later sample in the middle of its bit.
            if (!rx_s) begin
               baud_d  = HALF_LD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (!rx_s) begin
                  baud_d  = FULL_LD;
                  bit_d   = '0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               baud_d  = FULL_LD;
               bit_d   = bit_q + BW'(1);
               if (bit_q == LAST_BIT) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leaving at mid stop bit lets a back-to-back start bit be caught.
            if (tick) begin
               if (rx_s) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Delivery: a completed byte either lands in the output register (empty, or
   // being drained this cycle) or is dropped with an overrun pulse.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (done_q) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign frame_err   = ferr_q;
   assign overrun     = ovr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   import uart_pkg::*;

   localparam int DIV = 260; // 30 MHz / 115200, truncated

   logic        sys_clk;
   logic        sys_rst;
   logic        uart_line;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        frame_err;
   logic        overrun;
   uart_state_e dbg_state;

   int total = 0;
   int bad   = 0;
   int n_vcyc = 0, n_hs = 0, n_ferr = 0, n_ovr = 0;
   logic [7:0] exp_q[$];

   uart_rx #(.CLK_HZ(30000000), .BAUD(115200)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .uart_rx_i   (uart_line),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers: inputs change 1 time unit after the rising edge
   task automatic wait_clk();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      uart_line = 1'b0;
      repeat (DIV) wait_clk();
      for (int i = 0; i < 8; i++) begin
         uart_line = d[i];
         repeat (DIV) wait_clk();
      end
      uart_line = stop;
      repeat (DIV) wait_clk();
   endtask

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         if (rx_valid)  n_vcyc++;
         if (frame_err) n_ferr++;
         if (overrun)   n_ovr++;
         if (rx_valid && rx_ready) begin
            n_hs++;
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int cnt;
      int v0, h0, f0, o0;
      logic [7:0] rb;

      sys_rst   = 1'b0;
      uart_line = 1'b1;
      rx_ready  = 1'b1;
      repeat (5) wait_clk();
      sys_rst = 1'b1;
      wait_clk();

      // reset state
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (20) wait_clk();

      // 0x55, latency from pad edge, single-cycle valid
      v0 = n_vcyc; h0 = n_hs; f0 = n_ferr; o0 = n_ovr;
      exp_q.push_back(8'h55);
      cnt = 0;
      fork
         send_byte(8'h55, 1'b1);
         begin
            while (cnt < 3000) begin
               @(posedge sys_clk);
               cnt++;
               #1;
               if (rx_valid) break;
            end
         end
      join
      check("latency_0x55", 32'(cnt), 32'd2474);
      repeat (10) wait_clk();
      check("valid_cycles_0x55", 32'(n_vcyc - v0), 32'd1);
      check("hs_0x55", 32'(n_hs - h0), 32'd1);
      check("ferr_0x55", 32'(n_ferr - f0), 32'd0);
      check("ovr_0x55", 32'(n_ovr - o0), 32'd0);

      // 0xA3 then 0x0F back-to-back with no consumer: 0x0F overruns
      h0 = n_hs; o0 = n_ovr;
      rx_ready = 1'b0;
      exp_q.push_back(8'hA3);
      send_byte(8'hA3, 1'b1);
      send_byte(8'h0F, 1'b1);
      repeat (10) wait_clk();
      check("ovr_pulse_count", 32'(n_ovr - o0), 32'd1);
      check("held_rx_data", 32'(rx_data), 32'hA3);
      check("held_rx_valid", 32'(rx_valid), 32'd1);
      rx_ready = 1'b1;
      wait_clk();
      rx_ready = 1'b0;
      wait_clk();
      check("hs_after_ready", 32'(n_hs - h0), 32'd1);
      check("valid_after_hs", 32'(rx_valid), 32'd0);
      rx_ready = 1'b1;
      repeat (10) wait_clk();

      // 50-cycle low glitch
      v0 = n_vcyc; f0 = n_ferr;
      uart_line = 1'b0;
      repeat (50) wait_clk();
      uart_line = 1'b1;
      repeat (300) wait_clk();
      check("glitch_valid", 32'(n_vcyc - v0), 32'd0);
      check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
      check("glitch_state", 32'(dbg_state), 32'(ST_IDLE));

      // 0x81 with stop bit 0, then a long break
      v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
      send_byte(8'h81, 1'b0);
      repeat (5000) wait_clk();
      check("break_state", 32'(dbg_state), 32'(ST_BREAK));
      uart_line = 1'b1;
      repeat (20) wait_clk();
      check("break_ferr_count", 32'(n_ferr - f0), 32'd1);
      check("break_valid", 32'(n_vcyc - v0), 32'd0);
      check("break_ovr", 32'(n_ovr - o0), 32'd0);
      check("break_release_state", 32'(dbg_state), 32'(ST_IDLE));
      h0 = n_hs;
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      repeat (10) wait_clk();
      check("hs_0x3C", 32'(n_hs - h0), 32'd1);

      // reset pulse during data bit 4 of 0xFF
      h0 = n_hs;
      fork
         send_byte(8'hFF, 1'b1);
         begin
            repeat (5 * DIV + DIV / 2) wait_clk();
            check("pre_rst_state", 32'(dbg_state), 32'(ST_DATA));
            sys_rst = 1'b0;
            wait_clk();
            sys_rst = 1'b1;
            #4;
            check("mid_rst_rx_data", 32'(rx_data), 32'h00);
            check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
            check("mid_rst_frame_err", 32'(frame_err), 32'd0);
            check("mid_rst_overrun", 32'(overrun), 32'd0);
            check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
         end
      join
      repeat (10) wait_clk();
      check("hs_after_rst", 32'(n_hs - h0), 32'd0);
      h0 = n_hs;
      exp_q.push_back(8'h12);
      send_byte(8'h12, 1'b1);
      repeat (10) wait_clk();
      check("hs_0x12", 32'(n_hs - h0), 32'd1);

      // 16 random bytes back-to-back
      h0 = n_hs; f0 = n_ferr; o0 = n_ovr;
      for (int i = 0; i < 16; i++) begin
         rb = 8'($urandom_range(0, 255));
         exp_q.push_back(rb);
         send_byte(rb, 1'b1);
      end
      repeat (20) wait_clk();
      check("burst_hs", 32'(n_hs - h0), 32'd16);
      check("burst_ferr", 32'(n_ferr - f0), 32'd0);
      check("burst_ovr", 32'(n_ovr - o0), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
